fp_id_operand_unit: RTL and testbench

ID-stage consumer of the FP pipeline status buses driven by the pipelined FPU: e1n/e1w, e2n/e2w, e3n/e3w, ed, wn/ww, wd and st_ds.
Contains the FP register file, which is written from the FPU W stage. Supplies forwarded operands fa/fb to the FPU a/b inputs.
Raises the FP interlock stall when a source register is still in flight in E1/E2, or when the FPU reports st_ds.
Sits between instruction decode and the FPU. stall_fp feeds the ID/IF hold logic.

---
 rtl/fp_id_operand_unit_pkg.sv | 58 +++++
 rtl/fp_id_operand_unit_regfile.sv | 45 ++++
 rtl/fp_id_operand_unit.sv | 94 +++++++++
 tb/tb_fp_id_operand_unit.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_id_operand_unit_pkg.sv
// ---------------------------------------------------------------------------
// fp_id_operand_unit_pkg
// Shared definitions for the ID-stage FP operand unit:
//   - FP data width, register count and register index width
//   - forwarding select encodings reported on fwd_a / fwd_b
//   - fp_word / fp_regidx typedefs
//   - helper functions for the forwarding select and the E1/E2 RAW check
// ---------------------------------------------------------------------------
package fp_id_operand_unit_pkg;

  localparam int FP_WIDTH = 32;
  localparam int FP_NREG  = 32;
  localparam int FP_IDX_W = 5;

  // Forwarding source encodings
  localparam logic [1:0] FWD_RF = 2'd0;
  localparam logic [1:0] FWD_W  = 2'd1;
  localparam logic [1:0] FWD_E3 = 2'd2;

  typedef logic [FP_WIDTH-1:0] fp_word;
  typedef logic [FP_IDX_W-1:0] fp_regidx;

  // The E3 result is younger than the W result, so it wins when both target
  // the same register. An unused source always reads the register file.
  function automatic logic [1:0] fwd_select(
    input logic     use_src,
    input fp_regidx src,
    input logic     e3w,
    input fp_regidx e3n,
    input logic     ww,
    input fp_regidx wn
  );
    logic [1:0] sel;
    sel = FWD_RF;
    if (use_src) begin
      if (e3w && (e3n == src)) begin
        sel = FWD_E3;
      end else if (ww && (wn == src)) begin
        sel = FWD_W;
      end
    end
    return sel;
  endfunction

  // Results still in E1 or E2 cannot be forwarded yet; any match there is a
  // hazard regardless of older copies further down the pipe.
  function automatic logic raw_hazard(
    input logic     use_src,
    input fp_regidx src,
    input logic     e1w,
    input fp_regidx e1n,
    input logic     e2w,
    input fp_regidx e2n
  );
    return use_src && ((e1w && (e1n == src)) || (e2w && (e2n == src)));
  endfunction

endpackage

// File: rtl/fp_id_operand_unit_regfile.sv
// ---------------------------------------------------------------------------
// fp_regfile
// NREG x WIDTH floating-point register file.
//   clk   : rising-edge clock
//   clrn  : asynchronous active-low clear of every register
//   we    : write enable (W stage)
//   wa/wd : write address / write data
//   ra/rb : combinational read addresses
//   qa/qb : combinational read data
// f0 is an ordinary register; nothing is hardwired to zero.
// ---------------------------------------------------------------------------
module fp_regfile #(
  parameter int WIDTH = 32,
  parameter int NREG  = 32,
  parameter int IDX_W = $clog2(NREG)
) (
  input  logic             clk,
  input  logic             clrn,
  input  logic             we,
  input  logic [IDX_W-1:0] wa,
  input  logic [WIDTH-1:0] wd,
  input  logic [IDX_W-1:0] ra,
  input  logic [IDX_W-1:0] rb,
  output logic [WIDTH-1:0] qa,
  output logic [WIDTH-1:0] qb
);

  logic [WIDTH-1:0] regs [NREG];

  // Single write port. A write held across several cycles while the FPU is
  // frozen simply rewrites the same value.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      for (int i = 0; i < NREG; i++) begin
        regs[i] <= '0;
      end
    end else if (we) begin
      regs[wa] <= wd;
    end
  end

  assign qa = regs[ra];
  assign qb = regs[rb];

endmodule

// File: rtl/fp_id_operand_unit.sv
// ---------------------------------------------------------------------------
// fp_id_operand_unit
// ID-stage consumer of the pipelined FPU status buses. Holds the FP register
// file (written from the W stage), forwards operands to the FPU a/b inputs
// and raises the FP interlock stall.
//   clk, clrn              : clock / asynchronous active-low reset
//   fs, ft, use_fs, use_ft : sources of the instruction in ID
//   e1n/e1w, e2n/e2w       : destinations in E1/E2 (not yet forwardable)
//   e3n/e3w, ed            : destination and result in E3
//   wn/ww, wd              : W-stage write port
//   st_ds                  : divide/sqrt busy from the FPU
//   fa, fb                 : forwarded operands
//   fwd_a, fwd_b           : source used (0=regfile, 1=W, 2=E3)
//   stall_fp               : hold ID/IF and send a bubble to the FPU
// All outputs are combinational; the only state is the register file.
// ---------------------------------------------------------------------------
module fp_id_operand_unit
  import fp_id_operand_unit_pkg::*;
#(
  parameter int WIDTH = FP_WIDTH,
  parameter int NREG  = FP_NREG
) (
  input  logic             clk,
  input  logic             clrn,
  input  logic [4:0]       fs,
  input  logic [4:0]       ft,
  input  logic             use_fs,
  input  logic             use_ft,
  input  logic [4:0]       e1n,
  input  logic [4:0]       e2n,
  input  logic [4:0]       e3n,
  input  logic             e1w,
  input  logic             e2w,
  input  logic             e3w,
  input  logic [WIDTH-1:0] ed,
  input  logic [4:0]       wn,
  input  logic             ww,
  input  logic [WIDTH-1:0] wd,
  input  logic             st_ds,
  output logic [WIDTH-1:0] fa,
  output logic [WIDTH-1:0] fb,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic             stall_fp
);

  logic [WIDTH-1:0] rf_a;
  logic [WIDTH-1:0] rf_b;
  logic             raw_a;
  logic             raw_b;

  // The write is deliberately not gated by stall_fp: the W stage retires
  // independently of whatever is held in ID.
  fp_regfile #(
    .WIDTH (WIDTH),
    .NREG  (NREG),
    .IDX_W (FP_IDX_W)
  ) u_regfile (
    .clk  (clk),
    .clrn (clrn),
    .we   (ww),
    .wa   (wn),
    .wd   (wd),
    .ra   (fs),
    .rb   (ft),
    .qa   (rf_a),
    .qb   (rf_b)
  );

  // Operand a: W-stage forwarding doubles as same-cycle write-through.
  always_comb begin
    fwd_a = fwd_select(use_fs, fs, e3w, e3n, ww, wn);
    case (fwd_a)
      FWD_E3:  fa = ed;
      FWD_W:   fa = wd;
      default: fa = rf_a;
    endcase
  end

  // Operand b: same structure as operand a.
  always_comb begin
    fwd_b = fwd_select(use_ft, ft, e3w, e3n, ww, wn);
    case (fwd_b)
      FWD_E3:  fb = ed;
      FWD_W:   fb = wd;
      default: fb = rf_b;
    endcase
  end

  assign raw_a    = raw_hazard(use_fs, fs, e1w, e1n, e2w, e2n);
  assign raw_b    = raw_hazard(use_ft, ft, e1w, e1n, e2w, e2n);
  assign stall_fp = raw_a | raw_b | st_ds;

endmodule

// File: tb/tb_fp_id_operand_unit.sv
// ---------------------------------------------------------------------------
// tb_fp_id_operand_unit
// Scoreboard bench: the stimulus process drives one input vector per cycle
// and queues the response a reference model predicts; a monitor process
// pops and compares on every falling edge.
// ---------------------------------------------------------------------------
module tb_fp_id_operand_unit;
  import fp_id_operand_unit_pkg::*;

  typedef struct {
    logic     clrn;
    fp_regidx fs;
    fp_regidx ft;
    logic     use_fs;
    logic     use_ft;
    fp_regidx e1n;
    fp_regidx e2n;
    fp_regidx e3n;
    logic     e1w;
    logic     e2w;
    logic     e3w;
    fp_word   ed;
    fp_regidx wn;
    logic     ww;
    fp_word   wd;
    logic     st_ds;
  } stim_t;

  typedef struct {
    fp_word     fa;
    fp_word     fb;
    logic [1:0] fwd_a;
    logic [1:0] fwd_b;
    logic       stall;
    int         step;
  } exp_t;

  logic       clk;
  logic       clrn;
  fp_regidx   fs, ft, e1n, e2n, e3n, wn;
  logic       use_fs, use_ft, e1w, e2w, e3w, ww, st_ds;
  fp_word     ed, wd, fa, fb;
  logic [1:0] fwd_a, fwd_b;
  logic       stall_fp;

  fp_id_operand_unit dut (
    .clk      (clk),
    .clrn     (clrn),
    .fs       (fs),
    .ft       (ft),
    .use_fs   (use_fs),
    .use_ft   (use_ft),
    .e1n      (e1n),
    .e2n      (e2n),
    .e3n      (e3n),
    .e1w      (e1w),
    .e2w      (e2w),
    .e3w      (e3w),
    .ed       (ed),
    .wn       (wn),
    .ww       (ww),
    .wd       (wd),
    .st_ds    (st_ds),
    .fa       (fa),
    .fb       (fb),
    .fwd_a    (fwd_a),
    .fwd_b    (fwd_b),
    .stall_fp (stall_fp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Architectural view of the FP registers, updated at the edges where the
  // DUT is expected to write.
  fp_word model_rf [32];
  exp_t   sb [$];
  int     tests_run;
  int     tests_failed;
  int     step_no;
  stim_t  cur;

  function automatic stim_t idle_stim();
    stim_t s;
    s.clrn = 1'b1;  s.fs = '0;  s.ft = '0;  s.use_fs = 1'b0; s.use_ft = 1'b0;
    s.e1n = '0;     s.e2n = '0; s.e3n = '0; s.e1w = 1'b0;    s.e2w = 1'b0;
    s.e3w = 1'b0;   s.ed = '0;  s.wn = '0;  s.ww = 1'b0;     s.wd = '0;
    s.st_ds = 1'b0;
    return s;
  endfunction

  // Small index range so that producer/consumer matches are frequent.
  function automatic stim_t rand_stim();
    stim_t s;
    s = idle_stim();
    s.fs     = fp_regidx'($urandom_range(0, 7));
    s.ft     = fp_regidx'($urandom_range(0, 7));
    s.use_fs = 1'($urandom_range(0, 1));
    s.use_ft = 1'($urandom_range(0, 1));
    s.e1n    = fp_regidx'($urandom_range(0, 7));
    s.e2n    = fp_regidx'($urandom_range(0, 7));
    s.e3n    = fp_regidx'($urandom_range(0, 7));
    s.e1w    = 1'($urandom_range(0, 1));
    s.e2w    = 1'($urandom_range(0, 1));
    s.e3w    = 1'($urandom_range(0, 1));
    s.ed     = fp_word'($urandom);
    s.wn     = fp_regidx'($urandom_range(0, 7));
    s.ww     = 1'($urandom_range(0, 1));
    s.wd     = fp_word'($urandom);
    s.st_ds  = ($urandom_range(0, 7) == 0);
    return s;
  endfunction

  // Reference read: the newest value of the register visible to ID.
  // E3 holds a younger result than W; W is younger than the register file.
  function automatic fp_word model_read(input stim_t s, input logic use_src,
                                        input fp_regidx idx,
                                        output logic [1:0] src);
    if (use_src && s.e3w && s.e3n == idx) begin
      src = 2'd2;
      return s.ed;
    end
    if (use_src && s.ww && s.wn == idx) begin
      src = 2'd1;
      return s.wd;
    end
    src = 2'd0;
    return model_rf[idx];
  endfunction

  // Reference stall: a used source still being computed in E1/E2, or the
  // divider is busy.
  function automatic logic model_stall(input stim_t s);
    logic pend_a, pend_b;
    pend_a = s.use_fs && ((s.e1w && s.e1n == s.fs) || (s.e2w && s.e2n == s.fs));
    pend_b = s.use_ft && ((s.e1w && s.e1n == s.ft) || (s.e2w && s.e2n == s.ft));
    return pend_a || pend_b || s.st_ds;
  endfunction

  task automatic drive(input stim_t s);
    clrn = s.clrn; fs = s.fs; ft = s.ft; use_fs = s.use_fs; use_ft = s.use_ft;
    e1n = s.e1n; e2n = s.e2n; e3n = s.e3n; e1w = s.e1w; e2w = s.e2w;
    e3w = s.e3w; ed = s.ed; wn = s.wn; ww = s.ww; wd = s.wd; st_ds = s.st_ds;
  endtask

  task automatic applyStimulus(input stim_t s);
    exp_t e;
    @(posedge clk);
    if (cur.clrn && cur.ww) model_rf[cur.wn] = cur.wd;
    #1;
    drive(s);
    cur = s;
    if (!s.clrn) begin
      for (int i = 0; i < 32; i++) model_rf[i] = '0;
    end
    step_no++;
    e.fa    = model_read(s, s.use_fs, s.fs, e.fwd_a);
    e.fb    = model_read(s, s.use_ft, s.ft, e.fwd_b);
    e.stall = model_stall(s);
    e.step  = step_no;
    sb.push_back(e);
  endtask

  task automatic checkOutput(input string name, input int step,
                             input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s step %0d: got %h expected %h", name, step, act, exp);
    end
  endtask

  // Monitor: outputs are combinational, so the falling edge of the cycle
  // the vector was driven in is a stable sampling point.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      checkOutput("fa",       e.step, fa,               e.fa);
      checkOutput("fb",       e.step, fb,               e.fb);
      checkOutput("fwd_a",    e.step, {30'd0, fwd_a},   {30'd0, e.fwd_a});
      checkOutput("fwd_b",    e.step, {30'd0, fwd_b},   {30'd0, e.fwd_b});
      checkOutput("stall_fp", e.step, {31'd0, stall_fp}, {31'd0, e.stall});
    end
  end

  initial begin
    stim_t s;
    tests_run    = 0;
    tests_failed = 0;
    step_no      = 0;
    for (int i = 0; i < 32; i++) model_rf[i] = '0;
    cur      = idle_stim();
    cur.clrn = 1'b0;
    drive(cur);

    // Release reset and check the cleared state.
    s = idle_stim(); s.fs = 5'd3; s.ft = 5'd7; s.use_fs = 1'b1; s.use_ft = 1'b1;
    applyStimulus(s);

    // Write-through, then read back from the register file.
    s = idle_stim(); s.ww = 1'b1; s.wn = 5'd5; s.wd = 32'h3F800000;
    s.fs = 5'd5; s.use_fs = 1'b1;
    applyStimulus(s);
    s.ww = 1'b0;
    applyStimulus(s);

    // E3 beats W for the same register; W still lands in the register file.
    s = idle_stim(); s.e3w = 1'b1; s.e3n = 5'd4; s.ed = 32'h40000000;
    s.ww = 1'b1; s.wn = 5'd4; s.wd = 32'h40400000; s.fs = 5'd4; s.use_fs = 1'b1;
    applyStimulus(s);
    s = idle_stim(); s.fs = 5'd4; s.use_fs = 1'b1;
    applyStimulus(s);

    // Back-to-back dependency: producer walks E1, E2, E3.
    s = idle_stim(); s.e1w = 1'b1; s.e1n = 5'd2; s.ft = 5'd2; s.use_ft = 1'b1;
    applyStimulus(s);
    s = idle_stim(); s.e2w = 1'b1; s.e2n = 5'd2; s.ft = 5'd2; s.use_ft = 1'b1;
    applyStimulus(s);
    s = idle_stim(); s.e3w = 1'b1; s.e3n = 5'd2; s.ed = 32'h41200000;
    s.ft = 5'd2; s.use_ft = 1'b1;
    applyStimulus(s);

    // Pending in E1 stalls even with a stale copy in E3 and W.
    s = idle_stim(); s.e1w = 1'b1; s.e1n = 5'd1; s.e3w = 1'b1; s.e3n = 5'd1;
    s.ed = 32'h11111111; s.ww = 1'b1; s.wn = 5'd1; s.wd = 32'h22222222;
    s.fs = 5'd1; s.ft = 5'd1; s.use_fs = 1'b1; s.use_ft = 1'b1;
    applyStimulus(s);

    // Unused source never stalls.
    s = idle_stim(); s.e1w = 1'b1; s.e1n = 5'd6; s.fs = 5'd6;
    applyStimulus(s);

    // Divide/sqrt stall follows st_ds directly.
    s = idle_stim(); s.st_ds = 1'b1;
    applyStimulus(s);
    s.st_ds = 1'b0;
    applyStimulus(s);

    // Random traffic.
    for (int n = 0; n < 150; n++) begin
      applyStimulus(rand_stim());
    end

    // Reset mid-run, then release with nothing in flight.
    s = idle_stim(); s.clrn = 1'b0; s.fs = 5'd3; s.ft = 5'd7;
    s.use_fs = 1'b1; s.use_ft = 1'b1; s.st_ds = 1'b0;
    applyStimulus(s);
    s.clrn = 1'b1;
    applyStimulus(s);
    s.fs = 5'd5; s.ft = 5'd4;
    applyStimulus(s);

    for (int n = 0; n < 150; n++) begin
      applyStimulus(rand_stim());
    end

    // Bounded drain of the scoreboard.
    for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
    #1;
    if (sb.size() > 0) begin
      tests_run++;
      tests_failed++;
      $display("[TB] FAIL drain: got %0d pending expected 0", sb.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
